// File: rtl/fwft_rr_sched.sv
// fwft_rr_sched: round-robin drain of NQ FWFT FIFOs into one registered valid/ready stream.
// Build option: define FWFT_RR_SCHED_WEIGHT_EN to add per-queue burst limits on qweight.
module fwft_rr_sched #(
    parameter int NQ    = 4,
    parameter int DW    = 8,
    parameter int BURST = 4,
    parameter int QW    = (NQ > 1) ? $clog2(NQ) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NQ-1:0]    ffrvld,
    input  logic [NQ*DW-1:0] ffrdata,
    output logic [NQ-1:0]    ffrreq,
    output logic             out_vld,
    output logic [DW-1:0]    out_data,
    output logic [QW-1:0]    out_qid,
    input  logic             out_rdy,
`ifdef FWFT_RR_SCHED_WEIGHT_EN
    input  logic [NQ*8-1:0]  qweight,
`endif
    output logic             busy
);

    // Handshake: a word transfers on a rising edge where out_vld & out_rdy; out_data/out_qid
    // hold while out_vld & ~out_rdy. ffrreq pops the FWFT head word presented in that same cycle.

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [QW-1:0]   gnt, ptr, pick, gnt_next;
    logic            pick_found;
    logic [7:0]      bcnt, lim_raw, lim;
    logic            gnt_vld, pop, burst_end, rel;
    logic [DW-1:0]   fdata [NQ];

    always_comb begin
        for (int i = 0; i < NQ; i++) begin
            fdata[i] = ffrdata[i*DW +: DW];
        end
    end

`ifdef FWFT_RR_SCHED_WEIGHT_EN
    logic [7:0] wts [NQ];

    always_comb begin
        for (int i = 0; i < NQ; i++) begin
            wts[i] = qweight[i*8 +: 8];
        end
    end

    // Sampled every GRANT cycle so a weight change applies to the grant in progress.
    assign lim_raw = wts[gnt];
`else
    assign lim_raw = 8'(BURST);
`endif

    assign lim = (lim_raw == 8'd0) ? 8'd1 : lim_raw;

    // First valid queue at or after ptr, wrapping at NQ.
    always_comb begin
        pick_found = 1'b0;
        pick       = '0;
        for (int k = 0; k < NQ; k++) begin
            int s;
            s = int'(ptr) + k;
            if (s >= NQ) s = s - NQ;
            if (!pick_found && ffrvld[s[QW-1:0]]) begin
                pick_found = 1'b1;
                pick       = s[QW-1:0];
            end
        end
    end

    assign gnt_next  = (gnt == QW'(NQ - 1)) ? '0 : gnt + QW'(1);
    assign gnt_vld   = ffrvld[gnt];
    assign pop       = (state_q == GRANT) && gnt_vld && (!out_vld || out_rdy);
    assign burst_end = pop && (({1'b0, bcnt} + 9'd1) >= {1'b0, lim});
    assign rel       = (state_q == GRANT) && (!gnt_vld || burst_end);
    assign busy      = (state_q == GRANT);

    always_comb begin
        ffrreq = '0;
        if (reset_n && pop) ffrreq[gnt] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_found) state_d = GRANT;
            GRANT:   if (rel)        state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            gnt      <= '0;
            ptr      <= '0;
            bcnt     <= '0;
            out_vld  <= 1'b0;
            out_data <= '0;
            out_qid  <= '0;
        end else begin
            if (state_q == IDLE && pick_found) begin
                gnt  <= pick;
                bcnt <= '0;
            end
            if (rel) ptr <= gnt_next;
            if (pop) begin
                out_vld  <= 1'b1;
                out_data <= fdata[gnt];
                out_qid  <= gnt;
                bcnt     <= bcnt + 8'd1;
            end else if (out_rdy) begin
                out_vld  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fwft_rr_sched.sv
// Bench for fwft_rr_sched: FWFT FIFO models feed the DUT; a rotation model fills exp_q.
`timescale 1ns/1ps
module tb_fwft_rr_sched;

    localparam int NQ    = 4;
    localparam int DW    = 8;
    localparam int BURST = 4;
    localparam int QW    = 2;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [NQ-1:0]    ffrvld;
    logic [NQ*DW-1:0] ffrdata;
    logic [NQ-1:0]    ffrreq;
    logic             out_vld;
    logic [DW-1:0]    out_data;
    logic [QW-1:0]    out_qid;
    logic             out_rdy;
    logic             busy;
`ifdef FWFT_RR_SCHED_WEIGHT_EN
    logic [NQ*8-1:0]  qweight;
`endif

    logic [DW-1:0]    mem [NQ][64];
    int               rd_ptr [NQ];
    int               wr_ptr [NQ];
    int               n_checks = 0;
    int               n_pass   = 0;
    int               model_ptr = 0;
    logic [QW+DW-1:0] exp_q[$];

    fwft_rr_sched #(.NQ(NQ), .DW(DW), .BURST(BURST), .QW(QW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .ffrvld   (ffrvld),
        .ffrdata  (ffrdata),
        .ffrreq   (ffrreq),
        .out_vld  (out_vld),
        .out_data (out_data),
        .out_qid  (out_qid),
        .out_rdy  (out_rdy),
`ifdef FWFT_RR_SCHED_WEIGHT_EN
        .qweight  (qweight),
`endif
        .busy     (busy)
    );

    // ---------------- clock / FIFO models ----------------
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NQ; i++) begin
            ffrvld[i]           = (wr_ptr[i] != rd_ptr[i]);
            ffrdata[i*DW +: DW] = mem[i][6'(rd_ptr[i])];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NQ; i++) begin
            if (ffrreq[i]) rd_ptr[i] <= rd_ptr[i] + 1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input bit rdy);
        @(posedge clk);
        #1;
        out_rdy = rdy;
        #1;
    endtask

    task automatic flush_fifos();
        for (int i = 0; i < NQ; i++) wr_ptr[i] = rd_ptr[i];
    endtask

    task automatic push_word(input int q, input logic [DW-1:0] d);
        mem[q][6'(wr_ptr[q])] = d;
        wr_ptr[q] = wr_ptr[q] + 1;
    endtask

    task automatic load_random(input int q, input int n);
        for (int k = 0; k < n; k++) push_word(q, DW'($urandom));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        out_rdy = 1'b0;
        tick(1'b0);
        flush_fifos();
        tick(1'b0);
        reset_n   = 1'b1;
        model_ptr = 0;
        exp_q.delete();
    endtask

    function automatic bit fifos_empty();
        for (int i = 0; i < NQ; i++) if (wr_ptr[i] != rd_ptr[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drain_idle(output bit timed_out);
        timed_out = 1'b1;
        for (int n = 0; n < 60; n++) begin
            tick(1'b1);
            if (busy === 1'b0 && out_vld === 1'b0 && fifos_empty()) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int lim_of(input int q);
`ifdef FWFT_RR_SCHED_WEIGHT_EN
        int w;
        w = int'(qweight[q*8 +: 8]);
        return (w == 0) ? 1 : w;
`else
        return BURST;
`endif
    endfunction

    // Visit queues in rotation from model_ptr; each visit takes min(limit, remaining) words.
    task automatic build_expected();
        int cnt [NQ];
        int idx [NQ];
        int total;
        int g;
        total = 0;
        for (int i = 0; i < NQ; i++) begin
            cnt[i] = wr_ptr[i] - rd_ptr[i];
            idx[i] = rd_ptr[i];
            total += cnt[i];
        end
        while (total > 0) begin
            g = model_ptr;
            while (cnt[g] == 0) g = (g + 1) % NQ;
            for (int k = 0; k < lim_of(g) && cnt[g] > 0; k++) begin
                exp_q.push_back({QW'(g), mem[g][6'(idx[g])]});
                idx[g]++;
                cnt[g]--;
                total--;
            end
            model_ptr = (g + 1) % NQ;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int n;
        bit to;
        do_reset();
        n_checks++; if (out_vld !== 1'b0) $display("FAIL reset_out_vld: got %b want 0", out_vld); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (ffrreq !== '0) $display("FAIL reset_ffrreq: got %b want 0", ffrreq); else n_pass++;
        n_checks++; if (out_data !== '0) $display("FAIL reset_out_data: got %h want 0", out_data); else n_pass++;
        n_checks++; if (out_qid !== '0) $display("FAIL reset_out_qid: got %0d want 0", out_qid); else n_pass++;
        load_random(2, 6);
        n = 0;
        while (out_vld !== 1'b1 && n < 10) begin tick(1'b1); n++; end
        n_checks++; if (out_vld !== 1'b1) $display("FAIL reset_mid_vld: got %b want 1", out_vld); else n_pass++;
        reset_n = 1'b0;
        #1;
        n_checks++; if (ffrreq !== '0) $display("FAIL reset_low_ffrreq: got %b want 0", ffrreq); else n_pass++;
        flush_fifos();
        tick(1'b1);
        n_checks++; if (out_vld !== 1'b0) $display("FAIL reset_mid_out_vld: got %b want 0", out_vld); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_mid_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (ffrreq !== '0) $display("FAIL reset_mid_ffrreq: got %b want 0", ffrreq); else n_pass++;
        reset_n   = 1'b1;
        model_ptr = 0;
        push_word(3, 8'h33);
        push_word(0, 8'h00);
        n = 0;
        while (out_vld !== 1'b1 && n < 10) begin tick(1'b1); n++; end
        n_checks++; if (out_vld !== 1'b1 || out_qid !== QW'(0)) $display("FAIL reset_first_grant: got vld=%b qid=%0d want vld=1 qid=0", out_vld, out_qid); else n_pass++;
        drain_idle(to);
        n_checks++; if (to) $display("FAIL reset_drain: got timeout want idle"); else n_pass++;
    endtask

    task automatic test_single();
        logic [DW-1:0] w [6];
        bit ev [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        int wi;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            w[k] = DW'($urandom);
            push_word(2, w[k]);
        end
        wi = 0;
        for (int c = 0; c < 9; c++) begin
            tick(1'b1);
            n_checks++; if (out_vld !== ev[c]) $display("FAIL single_vld c%0d: got %b want %b", c + 1, out_vld, ev[c]); else n_pass++;
            if (ev[c] && wi < 6) begin
                n_checks++;
                if ({out_qid, out_data} !== {QW'(2), w[wi]})
                    $display("FAIL single_word %0d: got q%0d/%h want q2/%h", wi, out_qid, out_data, w[wi]);
                else n_pass++;
                wi++;
            end
        end
        n_checks++; if (busy !== 1'b0) $display("FAIL single_idle: got busy=%b want 0", busy); else n_pass++;
    endtask

    task automatic test_wrap();
        bit to;
        int n;
        do_reset();
        push_word(2, 8'h5a);
        drain_idle(to);
        n_checks++; if (to) $display("FAIL wrap_setup: got timeout want idle"); else n_pass++;
        push_word(0, 8'ha5);
        tick(1'b1);
        n_checks++; if (busy !== 1'b1) $display("FAIL wrap_grant: got busy=%b want 1", busy); else n_pass++;
        n_checks++; if (ffrreq !== NQ'(1)) $display("FAIL wrap_pop: got %b want 0001", ffrreq); else n_pass++;
        tick(1'b1);
        n_checks++; if (out_vld !== 1'b1 || out_qid !== QW'(0) || out_data !== 8'ha5) $display("FAIL wrap_word: got vld=%b q%0d/%h want vld=1 q0/a5", out_vld, out_qid, out_data); else n_pass++;
        n_checks++; if (busy !== 1'b1 || ffrreq !== '0) $display("FAIL wrap_empty_grant: got busy=%b ffrreq=%b want busy=1 ffrreq=0", busy, ffrreq); else n_pass++;
        tick(1'b1);
        n_checks++; if (busy !== 1'b0) $display("FAIL wrap_release: got busy=%b want 0", busy); else n_pass++;
        push_word(0, 8'h01);
        push_word(1, 8'h11);
        n = 0;
        while (out_vld !== 1'b1 && n < 10) begin tick(1'b1); n++; end
        n_checks++; if (out_vld !== 1'b1 || out_qid !== QW'(1)) $display("FAIL wrap_ptr: got vld=%b qid=%0d want vld=1 qid=1", out_vld, out_qid); else n_pass++;
        drain_idle(to);
    endtask

    task automatic test_rotation();
        bit ev[$];
        int eq[$];
        logic [QW+DW-1:0] want;
        do_reset();
        for (int q = 0; q < NQ; q++) load_random(q, 2 * lim_of(q));
        build_expected();
        ev.push_back(1'b0); eq.push_back(-1);
        for (int r = 0; r < 2 * NQ; r++) begin
            for (int k = 0; k < lim_of(r % NQ); k++) begin ev.push_back(1'b1); eq.push_back(r % NQ); end
            ev.push_back(1'b0); eq.push_back(-1);
        end
        while (ev.size() > 0) begin
            bit v;
            int qx;
            v  = ev.pop_front();
            qx = eq.pop_front();
            tick(1'b1);
            n_checks++; if (out_vld !== v) $display("FAIL rot_vld: got %b want %b", out_vld, v); else n_pass++;
            if (v && out_vld === 1'b1) begin
                n_checks++; if (out_qid !== QW'(qx)) $display("FAIL rot_qid: got %0d want %0d", out_qid, qx); else n_pass++;
                want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                n_checks++; if ({out_qid, out_data} !== want) $display("FAIL rot_data: got %h want %h", {out_qid, out_data}, want); else n_pass++;
            end
        end
        n_checks++; if (exp_q.size() != 0) $display("FAIL rot_leftover: got %0d words want 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_random_backpressure();
        logic [QW+DW-1:0] held, got, want;
        bit hold, did_stall, rdy;
        int stall_left, acc, cyc, tot, n;
        do_reset();
        for (int rnd = 0; rnd < 4; rnd++) begin
            tot = 0;
            for (int q = 0; q < NQ; q++) begin
                n = $urandom_range(0, 6);
                load_random(q, n);
                tot += n;
            end
            if (tot == 0) load_random($urandom_range(0, NQ - 1), 3);
            build_expected();
            hold = 1'b0; did_stall = 1'b0; acc = 0; cyc = 0; stall_left = 0; held = '0;
            while (exp_q.size() > 0 && cyc < 500) begin
                if (acc == 2 && !did_stall) begin stall_left = 5; did_stall = 1'b1; end
                rdy = (stall_left > 0) ? 1'b0 : ($urandom_range(0, 99) < 65);
                if (stall_left > 0) stall_left--;
                tick(rdy);
                got = {out_qid, out_data};
                if (hold) begin
                    n_checks++; if (out_vld !== 1'b1 || got !== held) $display("FAIL bp_hold: got vld=%b %h want vld=1 %h", out_vld, got, held); else n_pass++;
                end
                hold = (out_vld === 1'b1) && !rdy;
                if (hold) begin
                    held = got;
                    n_checks++; if (ffrreq !== '0) $display("FAIL bp_stall_ffrreq: got %b want 0", ffrreq); else n_pass++;
                end
                if (out_vld === 1'b1 && rdy) begin
                    want = exp_q.pop_front();
                    n_checks++; if (got !== want) $display("FAIL bp_data: got %h want %h", got, want); else n_pass++;
                    acc++;
                end
                cyc++;
            end
            n_checks++; if (exp_q.size() != 0) $display("FAIL bp_timeout: got %0d words pending want 0", exp_q.size()); else n_pass++;
            n = 0;
            while (!(busy === 1'b0 && out_vld === 1'b0) && n < 20) begin
                tick(1'b1);
                n_checks++; if (out_vld === 1'b1) $display("FAIL bp_extra: got word %h want none", {out_qid, out_data}); else n_pass++;
                n++;
            end
            n_checks++; if (busy !== 1'b0 || out_vld !== 1'b0) $display("FAIL bp_idle: got busy=%b vld=%b want 0/0", busy, out_vld); else n_pass++;
            exp_q.delete();
        end
    endtask

`ifdef FWFT_RR_SCHED_WEIGHT_EN
    task automatic test_weights();
        qweight = {8'd1, 8'd3, 8'd2, 8'd4};
        test_rotation();
        qweight[15:8] = 8'd0;
        test_rotation();
        qweight = {NQ{8'(BURST)}};
    endtask
`endif

    initial begin
        reset_n = 1'b0;
        out_rdy = 1'b0;
`ifdef FWFT_RR_SCHED_WEIGHT_EN
        qweight = {NQ{8'(BURST)}};
`endif
        test_reset();
        test_single();
        test_wrap();
        test_rotation();
        test_random_backpressure();
`ifdef FWFT_RR_SCHED_WEIGHT_EN
        test_weights();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion want finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
